// File: rtl/wavetable_loader_if.sv
// ---------------------------------------------------------------------------
// wavetable_loader_if
//   Groups the control, byte-stream and RAM write-port signals of the
//   wavetable loader.
//   Control : start, abort (in) / busy, done, err (out)
//   Stream  : in_data[7:0], in_valid (in) / in_ready (out)
//   RAM     : wr_en, wr_addr[ADDR_W-1:0], wr_data[DATA_W-1:0] (out)
//   modport slave  - the loader itself
//   modport master - whoever drives the stream and start/abort
// ---------------------------------------------------------------------------
interface wavetable_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
);
    logic              start;
    logic              abort;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, abort, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/wavetable_loader.sv
// ---------------------------------------------------------------------------
// wavetable_loader
//   Fills the wavetable sample RAM from a byte stream. Each sample arrives as
//   two bytes, low byte first; after a start pulse exactly 2^ADDR_W samples
//   are written to addresses 0..2^ADDR_W-1, then done pulses for one cycle.
//   High-byte bits above the sample width raise a sticky err flag (cleared by
//   the next accepted start); the sample is still written from the low bits.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - wavetable_loader_if.slave (start/abort, byte stream with
//              valid/ready, RAM write port, busy/done/err status)
// ---------------------------------------------------------------------------
module wavetable_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    wavetable_loader_if.slave  bus
);

    localparam int HI_W = DATA_W - 8;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True when the high byte carries bits that do not fit in the sample.
    function automatic logic hi_overflow(input logic [7:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i >= HI_W) begin
                r = r | b[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [7:0]        lo_r, lo_s;
    logic [HI_W-1:0]   hi_r, hi_s;
    logic              err_r, err_s;

    logic              in_ready_r, in_ready_s;
    logic              wr_en_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0] wr_data_r, wr_data_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    logic              xfer_s;
    logic              abort_s;

    // in_ready_r is high exactly in LOW/HIGH, so the handshake needs no state decode.
    assign xfer_s  = bus.in_valid && in_ready_r;
    assign abort_s = bus.abort && (state_r != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort outranks every transition outside IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (xfer_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (xfer_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_WRITE: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (addr_r == ADDR_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: address counter, byte latches and sticky error.
    always_comb begin
        addr_s = addr_r;
        lo_s   = lo_r;
        hi_s   = hi_r;
        err_s  = err_r;
        if ((state_r == ST_IDLE) && bus.start) begin
            addr_s = ADDR_ZERO;
            err_s  = 1'b0;
        end else if ((state_r == ST_LOW) && xfer_s && !abort_s) begin
            lo_s = bus.in_data;
        end else if ((state_r == ST_HIGH) && xfer_s && !abort_s) begin
            hi_s  = bus.in_data[HI_W-1:0];
            err_s = err_r | hi_overflow(bus.in_data);
        end else if ((state_r == ST_WRITE) && !abort_s && (addr_r != ADDR_LAST)) begin
            // The terminal address leaves addr untouched, so it never wraps.
            addr_s = addr_r + ADDR_ONE;
        end else begin
            addr_s = addr_r;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= ADDR_ZERO;
            lo_r   <= 8'h00;
            hi_r   <= {HI_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            addr_r <= addr_s;
            lo_r   <= lo_s;
            hi_r   <= hi_s;
            err_r  <= err_s;
        end
    end

    // Output decode from the next state, so every output leaves a flop that
    // already reflects the state the machine is entering.
    always_comb begin
        in_ready_s = (state_s == ST_LOW) || (state_s == ST_HIGH);
        wr_en_s    = (state_s == ST_WRITE);
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_DONE);
        if (state_s == ST_WRITE) begin
            // Entering WRITE from HIGH: addr_r is still this sample's address
            // and hi_s is the byte being accepted on this edge.
            wr_addr_s = addr_r;
            wr_data_s = {hi_s, lo_r};
        end else begin
            wr_addr_s = wr_addr_r;
            wr_data_s = wr_data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= ADDR_ZERO;
            wr_data_r  <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bus.in_ready = in_ready_r;
    // An abort raised during the WRITE cycle must keep the RAM from capturing,
    // so the strobe is gated here rather than waiting for the next edge.
    assign bus.wr_en    = wr_en_r & ~bus.abort;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_wavetable_loader.sv
// ---------------------------------------------------------------------------
// tb_wavetable_loader
//   Self-checking bench for wavetable_loader (ADDR_W=8, DATA_W=9). Each load
//   draws its byte table into a queue; expected writes, data and err are
//   computed arithmetically from that table.
// ---------------------------------------------------------------------------
module tb_wavetable_loader;

    localparam int AW = 8;
    localparam int DW = 9;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    wavetable_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wavetable_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] stim[$];

    int nw, n_done, n_xfer, viol;
    int first_wr, last_wr, done_cyc, fall_cyc, abort_cyc;
    bit finished, err_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample k from the table: low byte plus the high byte reduced to the sample width.
    function automatic logic [DW-1:0] model_sample(input int k);
        int v;
        logic [31:0] w;
        v = (int'(stim[2*k+1]) % (1 << (DW - 8))) * 256 + int'(stim[2*k]);
        w = v;
        return w[DW-1:0];
    endfunction

    // err after the first nsamp high bytes were accepted.
    function automatic bit model_err(input int nsamp);
        bit r;
        r = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            if (int'(stim[2*k+1]) >= (1 << (DW - 8))) r = 1'b1;
        end
        return r;
    endfunction

    task automatic build_stim(input bit legal_random, input bit counting);
        stim.delete();
        for (int k = 0; k < N; k++) begin
            if (counting) begin
                stim.push_back(8'(k));
                stim.push_back(8'(k & 1));
            end else begin
                stim.push_back(8'($urandom));
                stim.push_back(legal_random ? 8'($urandom_range(0, 1)) : 8'($urandom));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
        check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_err"},      32'(bus.err),      32'd0);
    endtask

    // One load: start at edge 0, stream the table with random gaps, log every
    // write/done, optionally abort or reset after a given number of accepted bytes.
    task automatic run_load(input int gap_pct, input int abort_idx, input int rst_idx,
                            input bit stray, input int budget);
        int idx;
        int cyc;
        bit took;
        nw = 0; n_done = 0; n_xfer = 0; viol = 0;
        first_wr = -1; last_wr = -1; done_cyc = -1; fall_cyc = -1; abort_cyc = -1;
        finished = 1'b0; err_done = 1'b0;
        idx = 0;
        bus.in_data  = stim[0];
        bus.in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
        bus.abort    = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        cyc = 0;
        #1;
        bus.start = 1'b0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            if (bus.wr_en) begin
                if (nw < N) begin
                    check("wr_addr", 32'(bus.wr_addr), 32'(nw));
                    check("wr_data", 32'(bus.wr_data), 32'(model_sample(nw)));
                end
                if (nw == 0) first_wr = cyc;
                last_wr = cyc;
                nw++;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                err_done = bus.err;
            end
            if (bus.in_ready && (bus.wr_en || bus.done || !bus.busy)) viol++;
            took = bus.in_valid && bus.in_ready;
            if (took) n_xfer++;
            if (!bus.busy) begin
                fall_cyc = cyc;
                finished = 1'b1;
                bus.start = 1'b0;
                bus.abort = 1'b0;
                bus.in_valid = 1'b0;
            end else begin
                @(posedge clk);
                cyc++;
                #1;
                if (took) idx++;
                if (rst_idx >= 0 && took && idx == rst_idx) begin
                    rst_n = 1'b0;
                    bus.start = 1'b0;
                    bus.abort = 1'b0;
                    bus.in_valid = 1'b0;
                    #1;
                    check_reset_outputs("midrst");
                    finished = 1'b1;
                end else begin
                    bus.abort = (abort_idx >= 0) && took && (idx == abort_idx);
                    if (bus.abort) abort_cyc = cyc;
                    bus.start = stray && ($urandom_range(0, 15) == 0);
                    bus.in_valid = (idx < stim.size()) && (int'($urandom_range(0, 99)) >= gap_pct);
                    bus.in_data = bus.in_valid ? stim[idx] : 8'($urandom);
                end
            end
        end
        check("load_ends", 32'(finished), 32'd1);
    endtask

    task automatic check_full_load(input string tag);
        check({tag, "_writes"}, 32'(nw), 32'(N));
        check({tag, "_xfers"}, 32'(n_xfer), 32'(2 * N));
        check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        check({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_wr + 1));
        check({tag, "_busy_fall"}, 32'(fall_cyc), 32'(done_cyc + 1));
        check({tag, "_err_at_done"}, 32'(err_done), 32'(model_err(N)));
        check({tag, "_ready_guard"}, 32'(viol), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back counting table: exact cycle positions.
        build_stim(1'b0, 1'b1);
        run_load(0, -1, -1, 1'b0, 2000);
        check_full_load("b2b");
        check("b2b_first_wr", 32'(first_wr), 32'd2);
        check("b2b_last_wr", 32'(last_wr), 32'd767);
        check("b2b_done_cyc", 32'(done_cyc), 32'd768);
        check("b2b_busy_fall", 32'(fall_cyc), 32'd769);

        // Random gaps, legal random data.
        build_stim(1'b1, 1'b0);
        run_load(40, -1, -1, 1'b0, 5000);
        check_full_load("gaps");

        // Oversized high byte at sample 5, stray starts while busy.
        build_stim(1'b1, 1'b0);
        stim[11] = 8'h03;
        run_load(30, -1, -1, 1'b1, 5000);
        check_full_load("ovf");
        check("ovf_err_held", 32'(bus.err), 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("restart_err_clr", 32'(bus.err), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("restart_abort_idle", 32'(bus.busy), 32'd0);
        check("restart_abort_no_done", 32'(bus.done), 32'd0);

        // Abort during the WRITE of addr 10 (after 22 accepted bytes).
        build_stim(1'b1, 1'b0);
        stim[7] = 8'h80;
        run_load(20, 22, -1, 1'b0, 3000);
        check("abort_writes", 32'(nw), 32'd10);
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_idle_next", 32'(fall_cyc), 32'(abort_cyc + 1));
        check("abort_err_kept", 32'(bus.err), 32'(model_err(11)));
        check("abort_ready_guard", 32'(viol), 32'd0);

        // Reset while in HIGH of sample 3 (after 7 accepted bytes).
        build_stim(1'b1, 1'b0);
        stim[3] = 8'hFF;
        run_load(25, -1, 7, 1'b0, 3000);
        check("rst_writes_before", 32'(nw), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh load after reset starts from addr 0.
        build_stim(1'b1, 1'b0);
        run_load(10, -1, -1, 1'b0, 5000);
        check_full_load("reload");
        check("reload_first_addr_cyc", 32'(first_wr >= 2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
